// File: rtl/rr_arbiter8_pkg.sv
// rr_arbiter8_pkg: shared constants and FSM encoding for the 8-way round-robin arbiter.
package rr_arbiter8_pkg;
    localparam int NREQ   = 8;
    localparam int CODE_W = 3;
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;
endpackage

// File: rtl/rr_arbiter8_enc8x3_onehot.sv
// enc8x3_onehot: combinational one-hot to binary encoder, 8 inputs to 3-bit code.
module enc8x3_onehot
    import rr_arbiter8_pkg::*;
(
    input  logic [NREQ-1:0]   onehot_i,
    output logic [CODE_W-1:0] code_o
);
    always_comb begin
        code_o = '0;
        for (int i = 0; i < NREQ; i++) code_o |= onehot_i[i] ? CODE_W'(i) : '0;
    end
endmodule

// File: rtl/rr_arbiter8.sv
// rr_arbiter8: round-robin arbiter over 8 requesters with registered one-hot/binary grant
// and a hold-time limit that preempts an owner while others wait.
module rr_arbiter8
    import rr_arbiter8_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    output logic [NREQ-1:0]   grant,
    output logic [CODE_W-1:0] grant_code,
    output logic              grant_valid,
    output logic              timeout
);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    state_e              state_q, state_d;
    logic [NREQ-1:0]     grant_q, grant_d;
    logic [CODE_W-1:0]   code_q, code_d, ptr_q, ptr_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                valid_q, timeout_q, timeout_d;
    logic [CODE_W:0]     pick_idle, pick_next;
    logic                limit_hit;

    // {hit, index} of the first set bit of r searching start, start+1, ... mod NREQ
    function automatic logic [CODE_W:0] pick(input logic [NREQ-1:0] r, input logic [CODE_W-1:0] start);
        logic [CODE_W-1:0] idx;
        pick = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = start + CODE_W'(i);
            if (r[idx]) pick = {1'b1, idx};
        end
    endfunction

    assign pick_idle = pick(req, ptr_q);
    assign pick_next = pick(req & ~grant_q, code_q + 1'b1);
    assign limit_hit = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            code_q    <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            ptr_q     <= '0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            code_q    <= code_d;
            valid_q   <= |grant_d;
            timeout_q <= timeout_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;
        if (state_q == IDLE) begin
            if (pick_idle[CODE_W]) begin
                state_d = BUSY;
                grant_d = NREQ'(1) << pick_idle[CODE_W-1:0];
                ptr_d   = pick_idle[CODE_W-1:0] + 1'b1;
                hold_d  = '0;
            end
        end else if (!req[code_q]) begin
            hold_d  = '0;
            state_d = pick_next[CODE_W] ? BUSY : IDLE;
            grant_d = pick_next[CODE_W] ? NREQ'(1) << pick_next[CODE_W-1:0] : '0;
            ptr_d   = pick_next[CODE_W] ? pick_next[CODE_W-1:0] + 1'b1 : ptr_q;
        end else if (limit_hit) begin
            // a lone owner keeps the grant and simply restarts its hold window
            hold_d    = '0;
            timeout_d = pick_next[CODE_W];
            grant_d   = pick_next[CODE_W] ? NREQ'(1) << pick_next[CODE_W-1:0] : grant_q;
            ptr_d     = pick_next[CODE_W] ? pick_next[CODE_W-1:0] + 1'b1 : ptr_q;
        end else begin
            hold_d = &hold_q ? hold_q : hold_q + 1'b1;
        end
    end

    enc8x3_onehot u_enc (
        .onehot_i (grant_d),
        .code_o   (code_d)
    );

    always_comb begin
        grant       = grant_q;
        grant_code  = code_q;
        grant_valid = valid_q;
        timeout     = timeout_q;
    end
endmodule

// File: tb/tb_rr_arbiter8.sv
// tb_rr_arbiter8: directed plan steps plus random traffic, each edge compared against a
// queue-free behavioural model that tracks owner, search pointer and cycles owned.
module tb_rr_arbiter8;
    localparam int MAXH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = '0;
    logic [7:0] grant;
    logic [2:0] grant_code;
    logic       grant_valid;
    logic       timeout;

    int n_cmp = 0;
    int n_bad = 0;

    int m_owner = -1;
    int m_ptr   = 0;
    int m_held  = 0;
    bit m_to    = 1'b0;

    rr_arbiter8 #(.MAX_HOLD(MAXH), .HOLD_W(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .grant       (grant),
        .grant_code  (grant_code),
        .grant_valid (grant_valid),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    function automatic int search(input logic [7:0] r, input int start);
        for (int k = 0; k < 8; k++) if (r[(start + k) % 8]) return (start + k) % 8;
        return -1;
    endfunction

    task automatic m_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_held  = 0;
        m_to    = 1'b0;
    endtask

    task automatic m_take(input int n);
        m_owner = n;
        m_ptr   = (n + 1) % 8;
        m_held  = 1;
    endtask

    task automatic m_edge();
        int n;
        logic [7:0] others;
        if (rst) begin
            m_reset();
            return;
        end
        m_to = 1'b0;
        if (m_owner < 0) begin
            n = search(req, m_ptr);
            if (n >= 0) m_take(n);
        end else begin
            others = req;
            others[m_owner] = 1'b0;
            n = search(others, m_owner + 1);
            if (!req[m_owner]) begin
                if (n >= 0) m_take(n);
                else begin
                    m_owner = -1;
                    m_held  = 0;
                end
            end else if (MAXH != 0 && m_held == MAXH) begin
                if (n >= 0) begin
                    m_take(n);
                    m_to = 1'b1;
                end else m_held = 1;
            end else m_held++;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        logic [7:0] eg;
        eg = '0;
        if (m_owner >= 0) eg[m_owner] = 1'b1;
        check({tag, ".grant"}, 32'(grant), 32'(eg));
        check({tag, ".code"}, 32'(grant_code), m_owner < 0 ? 32'd0 : 32'(m_owner));
        check({tag, ".valid"}, 32'(grant_valid), 32'(m_owner >= 0));
        check({tag, ".timeout"}, 32'(timeout), 32'(m_to));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        m_edge();
        #1;
        check_model(tag);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        @(posedge clk);
        m_reset();
        #1;
        check("reset.grant", 32'(grant), 32'd0);
        check("reset.code", 32'(grant_code), 32'd0);
        check("reset.valid", 32'(grant_valid), 32'd0);
        check("reset.timeout", 32'(timeout), 32'd0);
        rst = 1'b0;
    endtask

    task automatic async_reset(input string tag);
        #2 rst = 1'b1;
        #1 m_reset();
        check_model(tag);
        step(tag);
        rst = 1'b0;
    endtask

    initial begin
        apply_reset();

        req = 8'b0000_0100;
        step("t1.grant");
        check("t1.grant_const", 32'(grant), 32'h04);
        check("t1.code_const", 32'(grant_code), 32'd2);
        req = 8'h00;
        step("t1.idle");
        check("t1.idle_const", 32'(grant_valid), 32'd0);

        apply_reset();
        req = 8'b1000_0001;
        for (int i = 0; i < 4; i++) step("t2.own0");
        step("t2.switch7");
        check("t2.grant7", 32'(grant), 32'h80);
        check("t2.code7", 32'(grant_code), 32'd7);
        check("t2.to7", 32'(timeout), 32'd1);
        for (int i = 0; i < 3; i++) step("t2.own7");
        step("t2.wrap0");
        check("t2.grant0", 32'(grant), 32'h01);
        check("t2.to0", 32'(timeout), 32'd1);

        req = 8'b0010_1000;
        step("t3.own3");
        check("t3.grant3", 32'(grant), 32'h08);
        req = 8'b0010_0000;
        step("t3.handoff");
        check("t3.grant5", 32'(grant), 32'h20);
        check("t3.code5", 32'(grant_code), 32'd5);
        check("t3.no_to", 32'(timeout), 32'd0);

        req = 8'b0100_0000;
        for (int i = 0; i < 40; i++) begin
            step("t4.single");
            check("t4.grant6", 32'(grant), 32'h40);
            check("t4.no_to", 32'(timeout), 32'd0);
        end

        async_reset("t5.async");
        check("t5.async_grant", 32'(grant), 32'd0);
        req = 8'hFF;
        step("t5.first");
        check("t5.grant0", 32'(grant), 32'h01);

        for (int i = 0; i < 3; i++) step("t6.hold");
        req = 8'hFE;
        step("t6.coincide");
        check("t6.grant1", 32'(grant), 32'h02);
        check("t6.no_to", 32'(timeout), 32'd0);

        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 7))
                0, 1: req = 8'($urandom);
                2:    req = 8'($urandom & $urandom & $urandom);
                3:    req[$urandom_range(0, 7)] ^= 1'b1;
                default: ;
            endcase
            if ($urandom_range(0, 59) == 0) async_reset("rnd.async");
            else step("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
